wave_mixer: RTL
===============

Name: wave_mixer

Overview:
- Parametrised, pipelined signed mixer. Sums CHANNELS signed WIDTH-bit wave samples through a registered adder tree.
- Applies an arithmetic right shift, then saturates the result back to WIDTH bits.
- Uses a valid/ready handshake at both ports and counts clipping events.
- Sits between the per-channel oscillators and the output DAC/serialiser. Replaces the single-cycle two-input clocked adder.

Parameters:
- WIDTH, 16, sample width in bits (signed two's complement), 8..32.
- CHANNELS, 4, number of input channels; power of 2, 2..16.
- SHIFT, 0, arithmetic right shift applied to the full-precision sum before saturation; 0..log2(CHANNELS).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_data holds a sample set.
- in_ready  out  1  mixer accepts in_data this cycle.
- in_data  in  CHANNELS*WIDTH  channel k in bits [k*WIDTH +: WIDTH], signed.
- out_valid  out  1  out_data holds a mixed sample.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  WIDTH  mixed, shifted, saturated sample, signed.
- clip_clear  in  1  synchronous clear of clip_count.
- clip_count  out  16  number of saturated outputs produced.

Behaviour:
- Reset (async assert, sync release) clears all stage valid bits, all stage data, out_data and clip_count to 0. After release, in_ready=1.
- Pipeline structure: L = log2(CHANNELS) tree stages, then one shift/saturate stage. Latency is L+1 cycles from the accepted input to out_valid when not stalled. For CHANNELS=4 the latency is 3.
- Tree width grows by one bit per level. Final full-precision width is WIDTH+L. No intermediate overflow is possible.
- Global stall: advance = !out_valid | out_ready.
  - in_ready = advance.
  - Input is accepted when in_valid & in_ready.
  - On advance, every stage loads from its predecessor, including its valid bit. Bubbles (valid=0) propagate normally.
  - When advance=0, all stages hold. out_data and out_valid must remain stable while out_valid & !out_ready.
- in_ready depends only on registered out_valid and the out_ready input. There is no combinational path from in_valid.
- Shift/saturate stage:
  - s = sum >>> SHIFT (sign-preserving).
  - If s > 2^(WIDTH-1)-1, out = 2^(WIDTH-1)-1.
  - If s < -2^(WIDTH-1), out = -2^(WIDTH-1).
  - Otherwise out = s[WIDTH-1:0].
  - The clip flag is set when either limit is applied.
- clip_count increments by 1 when the final stage loads a valid clipped sample (on advance). It saturates at 16'hFFFF and does not wrap.
- clip_clear has priority: clip_count becomes 0 even if a clip occurs in the same cycle.
- Sample ordering is strictly preserved. No sample is dropped or duplicated under any out_ready pattern.
- rst_n asserted mid-stream discards all in-flight samples immediately. out_valid is 0 in the same cycle.

Optional Feature:
- Macro: WAVE_MIXER_MUTE_EN.
- Defined: adds port mute_mask, input, width CHANNELS. Bit k=1 forces channel k to 0 at input capture, sampled in the acceptance cycle. mute_mask=all-ones yields out_data=0 with no clip.
- Undefined: the port is absent and all channels are always summed.

Decomposition:
- Shared package wave_pkg holds:
  - SAMPLE_W default (16).
  - Functions sat_max(w) and sat_min(w).
  - A clog2 helper.
  - CLIP_CNT_W = 16.
- Natural sub-module: wave_mixer_stage, one registered adder-tree level.
  - Parameters: IN_W, N_IN.
  - Takes N_IN operands of IN_W bits and outputs N_IN/2 sums of IN_W+1 bits.
  - Ports: clk, rst_n, en, valid_in, valid_out.
  - Instantiated L times by a generate loop.

Test Plan:
- Reset: hold rst_n=0, toggle inputs -> out_valid=0, out_data=0, clip_count=0. After release, in_ready=1.
- Basic (W=16, C=4, SHIFT=0): in {100,200,-50,25}, out_ready=1 -> out_data=275 exactly 3 cycles later, single out_valid pulse, clip_count=0.
- Saturation: {0x7FFF x4} -> 0x7FFF, clip_count=1. Then {0x8000 x4} -> 0x8000, clip_count=2. Then clip_clear with a clipping sample in the same cycle -> clip_count=0.
- Backpressure: stream values 1..6 (all channels equal), out_ready=0 for 4 cycles mid-stream -> in_ready=0 while stalled, out_data stable while stalled, outputs 4,8,12,16,20,24 in order with none lost.
- Shift (SHIFT=2 instance): {0x7FFF x4} -> 32767 with no clip. {-1,0,0,0} -> -1. {3,0,0,0} -> 0.
- Mute (WAVE_MIXER_MUTE_EN): mute_mask=4'b0010 with {100,200,-50,25} -> 75. mute_mask=4'b1111 -> 0.

Source files
------------

// File: rtl/wave_pkg.sv
// Shared constants and helpers for the wave mixer: sample width, clip counter width,
// saturation limits and a constant-evaluable clog2.
package wave_pkg;

   localparam int SAMPLE_W   = 16;
   localparam int CLIP_CNT_W = 16;

   function automatic int clog2(input int unsigned v);
      int          r;
      int unsigned x;
      r = 0;
      x = 1;
      while (x < v) begin
         x = x << 1;
         r++;
      end
      return r;
   endfunction

   function automatic longint sat_max(input int w);
      return (64'sd1 <<< (w - 1)) - 64'sd1;
   endfunction

   function automatic longint sat_min(input int w);
      return -(64'sd1 <<< (w - 1));
   endfunction

endpackage

// File: rtl/wave_mixer_stage.sv
// One registered adder-tree level: N_IN signed operands of IN_W bits are summed
// pairwise into N_IN/2 signed results of IN_W+1 bits.
module wave_mixer_stage
   import wave_pkg::*;
#(
   parameter int IN_W = SAMPLE_W,
   parameter int N_IN = 4
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             en,
   input  logic                             valid_in,
   input  logic [N_IN*IN_W-1:0]             data_in,
   output logic                             valid_out,
   output logic [(N_IN/2)*(IN_W+1)-1:0]     data_out
);

   localparam int N_OUT = N_IN / 2;
   localparam int OUT_W = IN_W + 1;

   logic [N_OUT*OUT_W-1:0] sum_d;
   logic [N_OUT*OUT_W-1:0] sum_q;
   logic                   valid_q;

   always_comb begin
      sum_d = '0;
      for (int unsigned k = 0; k < N_OUT; k++) begin
         sum_d[k*OUT_W +: OUT_W] = OUT_W'($signed(data_in[(2*k)*IN_W +: IN_W]))
                                 + OUT_W'($signed(data_in[(2*k+1)*IN_W +: IN_W]));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         sum_q   <= '0;
      end else if (en) begin
         valid_q <= valid_in;
         sum_q   <= sum_d;
      end
   end

   assign valid_out = valid_q;
   assign data_out  = sum_q;

endmodule

// File: rtl/wave_mixer.sv
// Pipelined signed mixer: registered adder tree, arithmetic shift, saturation, clip counter.
// Optional per-channel muting when WAVE_MIXER_MUTE_EN is defined.
module wave_mixer
   import wave_pkg::*;
#(
   parameter int WIDTH    = SAMPLE_W,
   parameter int CHANNELS = 4,
   parameter int SHIFT    = 0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
`ifdef WAVE_MIXER_MUTE_EN
   input  logic [CHANNELS-1:0]       mute_mask,
`endif
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [WIDTH-1:0]          out_data,
   input  logic                      clip_clear,
   output logic [CLIP_CNT_W-1:0]     clip_count
);

   localparam int L     = clog2(CHANNELS);
   localparam int SUM_W = WIDTH + L;
   localparam logic signed [SUM_W-1:0] MAX_V = SUM_W'(sat_max(WIDTH));
   localparam logic signed [SUM_W-1:0] MIN_V = SUM_W'(sat_min(WIDTH));

   logic                      advance;
   logic [CHANNELS*WIDTH-1:0] cap_data;
   logic [SUM_W-1:0]          sum_full;
   logic                      sum_valid;
   logic signed [SUM_W-1:0]   shifted;
   logic [WIDTH-1:0]          sat_d;
   logic                      clip_d;
   logic                      out_valid_q;
   logic [WIDTH-1:0]          out_data_q;
   logic [CLIP_CNT_W-1:0]     clip_cnt_d;
   logic [CLIP_CNT_W-1:0]     clip_cnt_q;

   // Single global enable: the whole pipe moves only when the output slot can take a new sample.
   assign advance  = !out_valid_q || out_ready;
   assign in_ready = advance;

   always_comb begin
      cap_data = in_data;
`ifdef WAVE_MIXER_MUTE_EN
      for (int unsigned k = 0; k < CHANNELS; k++) begin
         if (mute_mask[k]) cap_data[k*WIDTH +: WIDTH] = '0;
      end
`endif
   end

   for (genvar g = 0; g < L; g++) begin : lvl
      localparam int IW = WIDTH + g;
      localparam int NI = CHANNELS >> g;

      logic [NI*IW-1:0]          din;
      logic                      vin;
      logic [(NI/2)*(IW+1)-1:0]  dout;
      logic                      vout;

      if (g == 0) begin : src
         assign din = cap_data;
         assign vin = in_valid;
      end else begin : src
         assign din = lvl[g-1].dout;
         assign vin = lvl[g-1].vout;
      end

      wave_mixer_stage #(
         .IN_W (IW),
         .N_IN (NI)
      ) u_stage (
         .clk       (clk),
         .rst_n     (rst_n),
         .en        (advance),
         .valid_in  (vin),
         .data_in   (din),
         .valid_out (vout),
         .data_out  (dout)
      );
   end

   assign sum_full  = lvl[L-1].dout;
   assign sum_valid = lvl[L-1].vout;

   always_comb begin
      shifted = $signed(sum_full) >>> SHIFT;
      clip_d  = 1'b0;
      sat_d   = shifted[WIDTH-1:0];
      if (shifted > MAX_V) begin
         sat_d  = MAX_V[WIDTH-1:0];
         clip_d = 1'b1;
      end else if (shifted < MIN_V) begin
         sat_d  = MIN_V[WIDTH-1:0];
         clip_d = 1'b1;
      end
   end

   // Clear wins over a simultaneous clip; the count sticks at all-ones.
   always_comb begin
      clip_cnt_d = clip_cnt_q;
      if (clip_clear) begin
         clip_cnt_d = '0;
      end else if (advance && sum_valid && clip_d && (clip_cnt_q != '1)) begin
         clip_cnt_d = clip_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         clip_cnt_q  <= '0;
      end else begin
         clip_cnt_q <= clip_cnt_d;
         if (advance) begin
            out_valid_q <= sum_valid;
            out_data_q  <= sat_d;
         end
      end
   end

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign clip_count = clip_cnt_q;

endmodule
